// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the mult/div sequencer: FSM states, operation select
// and exception cause values.
package muldiv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } seqStateT;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam logic CAUSE_DIVZERO = 1'b0;
    localparam logic CAUSE_TIMEOUT = 1'b1;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Handshake bundle between the control unit / arithmetic units and the
// mult/div sequencer. The sequencer uses the slave view.
interface muldiv_sequencer_if;

    logic op_valid;
    logic op_sel;
    logic flush;
    logic mult_end;
    logic div_end;
    logic div_zero;
    logic MultCtrl;
    logic DivCtrl;
    logic HILOCtrl;
    logic WriteHILO;
    logic busy;
    logic done;
    logic exc;
    logic exc_cause;

    modport master (
        output op_valid, op_sel, flush, mult_end, div_end, div_zero,
        input  MultCtrl, DivCtrl, HILOCtrl, WriteHILO, busy, done, exc, exc_cause
    );

    modport slave (
        input  op_valid, op_sel, flush, mult_end, div_end, div_zero,
        output MultCtrl, DivCtrl, HILOCtrl, WriteHILO, busy, done, exc, exc_cause
    );

endinterface

// File: rtl/muldiv_sequencer_wait_counter.sv
// Wait-cycle counter for the sequencer: clears, counts while enabled and
// holds at the terminal count (TIMEOUT_CYCLES-1), flagging it.
module muldiv_wait_counter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic termCnt
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    assign termCnt = (count == TC_VAL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !termCnt) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences one MULT/DIV at a time through the shared units and the HI/LO
// write, with divide-by-zero and timeout exceptions and a synchronous flush.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input logic                clk,
    input logic                reset,
    muldiv_sequencer_if.slave  bus
);

    seqStateT state;
    seqStateT nextState;
    logic     opReg;
    logic     nextOp;
    logic     excCause;
    logic     nextCause;
    logic     termCnt;
    logic     selEnd;

    logic multCtrlQ;
    logic divCtrlQ;
    logic writeHiloQ;
    logic busyQ;
    logic doneQ;
    logic excQ;

    // Only the end flag of the unit actually started is honoured.
    assign selEnd = (opReg == OP_DIV) ? bus.div_end : bus.mult_end;

    muldiv_wait_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_waitCounter (
        .clk     (clk),
        .reset   (reset),
        .clr     ((state == START) || bus.flush),
        .en      (state == WAIT),
        .termCnt (termCnt)
    );

    always_comb begin
        nextState = state;
        nextOp    = opReg;
        nextCause = excCause;
        if (bus.flush) begin
            nextState = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.op_valid) begin
                        nextState = START;
                        nextOp    = bus.op_sel;
                    end
                end
                START: nextState = WAIT;
                WAIT: begin
                    if (selEnd) begin
                        if ((opReg == OP_DIV) && bus.div_zero) begin
                            nextState = ERR;
                            nextCause = CAUSE_DIVZERO;
                        end else begin
                            nextState = WRITE;
                        end
                    end else if (termCnt) begin
                        nextState = ERR;
                        nextCause = CAUSE_TIMEOUT;
                    end
                end
                WRITE:   nextState = DONE;
                DONE:    nextState = IDLE;
                ERR:     nextState = IDLE;
                default: nextState = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            opReg      <= OP_MULT;
            excCause   <= CAUSE_DIVZERO;
            multCtrlQ  <= 1'b0;
            divCtrlQ   <= 1'b0;
            writeHiloQ <= 1'b0;
            busyQ      <= 1'b0;
            doneQ      <= 1'b0;
            excQ       <= 1'b0;
        end else begin
            state      <= nextState;
            opReg      <= nextOp;
            excCause   <= nextCause;
            multCtrlQ  <= (nextState == START) && (nextOp == OP_MULT);
            divCtrlQ   <= (nextState == START) && (nextOp == OP_DIV);
            writeHiloQ <= (nextState == WRITE);
            busyQ      <= (nextState != IDLE);
            doneQ      <= (nextState == DONE);
            excQ       <= (nextState == ERR);
        end
    end

    assign bus.MultCtrl  = multCtrlQ;
    assign bus.DivCtrl   = divCtrlQ;
    assign bus.HILOCtrl  = opReg;
    assign bus.WriteHILO = writeHiloQ;
    assign bus.busy      = busyQ;
    assign bus.done      = doneQ;
    assign bus.exc       = excQ;
    assign bus.exc_cause = excCause;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer (TIMEOUT_CYCLES = 8).
module tb_muldiv_sequencer;

    logic clk;
    logic reset;

    muldiv_sequencer_if bus();

    muldiv_sequencer #(
        .TIMEOUT_CYCLES (8),
        .CNT_W          (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int testsRun    = 0;
    int testsFailed = 0;
    int nMult, nDiv, nWrite, nDone, nExc, nBusy;
    int waitCnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input int got, input int exp);
        testsRun++;
        if (got != exp) begin
            testsFailed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clearCounts();
        nMult = 0; nDiv = 0; nWrite = 0; nDone = 0; nExc = 0; nBusy = 0;
    endtask

    // Advance one clock, then tally the pulses seen in the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        nMult  += int'(bus.MultCtrl);
        nDiv   += int'(bus.DivCtrl);
        nWrite += int'(bus.WriteHILO);
        nDone  += int'(bus.done);
        nExc   += int'(bus.exc);
        nBusy  += int'(bus.busy);
    endtask

    initial begin
        reset        = 1'b0;
        bus.op_valid = 1'b0;
        bus.op_sel   = 1'b0;
        bus.flush    = 1'b0;
        bus.mult_end = 1'b0;
        bus.div_end  = 1'b0;
        bus.div_zero = 1'b0;
        #12;
        checkVal("rst_MultCtrl",  int'(bus.MultCtrl),  0);
        checkVal("rst_DivCtrl",   int'(bus.DivCtrl),   0);
        checkVal("rst_HILOCtrl",  int'(bus.HILOCtrl),  0);
        checkVal("rst_WriteHILO", int'(bus.WriteHILO), 0);
        checkVal("rst_busy",      int'(bus.busy),      0);
        checkVal("rst_done",      int'(bus.done),      0);
        checkVal("rst_exc",       int'(bus.exc),       0);
        checkVal("rst_exc_cause", int'(bus.exc_cause), 0);
        reset = 1'b1;
        tick();
        checkVal("idle_busy", int'(bus.busy), 0);

        // MULT nominal, mult_end on the third WAIT cycle
        clearCounts();
        bus.op_valid = 1'b1; bus.op_sel = 1'b0;
        tick();
        checkVal("mul_start_MultCtrl", int'(bus.MultCtrl), 1);
        checkVal("mul_start_DivCtrl",  int'(bus.DivCtrl),  0);
        checkVal("mul_start_HILOCtrl", int'(bus.HILOCtrl), 0);
        checkVal("mul_start_busy",     int'(bus.busy),     1);
        bus.op_valid = 1'b0;
        tick();
        checkVal("mul_w1_MultCtrl", int'(bus.MultCtrl), 0);
        tick();
        tick();
        bus.mult_end = 1'b1;
        tick();
        checkVal("mul_write_WriteHILO", int'(bus.WriteHILO), 1);
        checkVal("mul_write_done",      int'(bus.done),      0);
        checkVal("mul_write_HILOCtrl",  int'(bus.HILOCtrl),  0);
        bus.mult_end = 1'b0;
        tick();
        checkVal("mul_done_done",      int'(bus.done),      1);
        checkVal("mul_done_WriteHILO", int'(bus.WriteHILO), 0);
        tick();
        checkVal("mul_idle_busy", int'(bus.busy), 0);
        checkVal("mul_nMult",  nMult,  1);
        checkVal("mul_nDiv",   nDiv,   0);
        checkVal("mul_nWrite", nWrite, 1);
        checkVal("mul_nDone",  nDone,  1);
        checkVal("mul_nBusy",  nBusy,  6);

        // DIV by zero in the first WAIT cycle
        clearCounts();
        bus.op_valid = 1'b1; bus.op_sel = 1'b1;
        tick();
        checkVal("dz_start_DivCtrl",  int'(bus.DivCtrl),  1);
        checkVal("dz_start_MultCtrl", int'(bus.MultCtrl), 0);
        checkVal("dz_start_HILOCtrl", int'(bus.HILOCtrl), 1);
        bus.op_valid = 1'b0;
        bus.div_end = 1'b1; bus.div_zero = 1'b1;
        tick();
        tick();
        checkVal("dz_err_exc",       int'(bus.exc),       1);
        checkVal("dz_err_exc_cause", int'(bus.exc_cause), 0);
        bus.div_end = 1'b0; bus.div_zero = 1'b0;
        tick();
        checkVal("dz_idle_busy", int'(bus.busy), 0);
        checkVal("dz_idle_exc",  int'(bus.exc),  0);
        checkVal("dz_nWrite", nWrite, 0);
        checkVal("dz_nDiv",   nDiv,   1);
        checkVal("dz_nExc",   nExc,   1);
        checkVal("dz_nDone",  nDone,  0);

        // DIV timeout with a stray mult_end pulse during WAIT
        clearCounts();
        bus.op_valid = 1'b1; bus.op_sel = 1'b1;
        tick();
        bus.op_valid = 1'b0;
        waitCnt = 0;
        while (!bus.exc && waitCnt < 20) begin
            bus.mult_end = (waitCnt == 2);
            tick();
            waitCnt++;
        end
        bus.mult_end = 1'b0;
        checkVal("to_cycles_to_exc", waitCnt, 9);
        checkVal("to_exc_cause", int'(bus.exc_cause), 1);
        checkVal("to_nWrite", nWrite, 0);
        checkVal("to_nExc",   nExc,   1);
        tick();
        checkVal("to_idle_busy", int'(bus.busy), 0);

        // Flush mid-WAIT, stray op_valid while busy and with flush in IDLE
        clearCounts();
        bus.op_valid = 1'b1; bus.op_sel = 1'b0;
        tick();
        bus.op_valid = 1'b0;
        tick();
        bus.op_valid = 1'b1; bus.op_sel = 1'b1;
        tick();
        checkVal("fl_w2_busy",     int'(bus.busy),     1);
        checkVal("fl_w2_HILOCtrl", int'(bus.HILOCtrl), 0);
        bus.op_valid = 1'b0;
        bus.flush = 1'b1;
        tick();
        checkVal("fl_idle_busy", int'(bus.busy), 0);
        bus.op_valid = 1'b1;
        tick();
        checkVal("fl_drop_busy", int'(bus.busy), 0);
        bus.flush = 1'b0; bus.op_valid = 1'b0;
        tick();
        checkVal("fl_still_idle", int'(bus.busy), 0);
        checkVal("fl_nWrite", nWrite, 0);
        checkVal("fl_nDone",  nDone,  0);
        checkVal("fl_nExc",   nExc,   0);
        checkVal("fl_nDiv",   nDiv,   0);
        checkVal("fl_cause_kept", int'(bus.exc_cause), 1);
        bus.op_valid = 1'b1; bus.op_sel = 1'b1;
        tick();
        checkVal("fl_fresh_DivCtrl", int'(bus.DivCtrl), 1);
        bus.op_valid = 1'b0;
        bus.div_end = 1'b1;
        tick();
        tick();
        checkVal("fl_fresh_WriteHILO", int'(bus.WriteHILO), 1);
        checkVal("fl_fresh_HILOCtrl",  int'(bus.HILOCtrl),  1);
        bus.div_end = 1'b0;
        tick();
        checkVal("fl_fresh_done", int'(bus.done), 1);
        tick();

        // Back-to-back MULT then DIV, then async reset mid-WAIT
        bus.op_valid = 1'b1; bus.op_sel = 1'b0;
        tick();
        bus.op_valid = 1'b0;
        bus.mult_end = 1'b1;
        tick();
        tick();
        bus.mult_end = 1'b0;
        tick();
        checkVal("b2b_done", int'(bus.done), 1);
        bus.op_valid = 1'b1; bus.op_sel = 1'b1;
        tick();
        checkVal("b2b_gap_busy", int'(bus.busy), 0);
        tick();
        checkVal("b2b_start2_DivCtrl", int'(bus.DivCtrl), 1);
        checkVal("b2b_start2_busy",    int'(bus.busy),    1);
        bus.op_valid = 1'b0;
        tick();
        tick();
        checkVal("rw_wait_busy", int'(bus.busy), 1);
        #2;
        reset = 1'b0;
        #1;
        checkVal("rw_busy",      int'(bus.busy),      0);
        checkVal("rw_HILOCtrl",  int'(bus.HILOCtrl),  0);
        checkVal("rw_DivCtrl",   int'(bus.DivCtrl),   0);
        checkVal("rw_WriteHILO", int'(bus.WriteHILO), 0);
        checkVal("rw_exc",       int'(bus.exc),       0);
        checkVal("rw_done",      int'(bus.done),      0);
        checkVal("rw_exc_cause", int'(bus.exc_cause), 0);
        #2;
        reset = 1'b1;
        tick();
        checkVal("rw_post_busy", int'(bus.busy), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
